// File: rtl/axi_bridge_pkg.sv
// axi_bridge_pkg: shared types and constants for the
// FFT sample-RAM streaming bridge.
package axi_bridge_pkg;

   localparam int IDX_W = 12;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WAIT,
      WRITE
   } bridge_fsm;

endpackage

// File: rtl/axi_bridge.sv
// axi_bridge: loads N samples into the FFT RAM, waits for
// the core, then streams the N results back out.
module axi_bridge
   import axi_bridge_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [DATA_WIDTH-1:0] i_ARDATA,
   input  logic                  i_ARVALID,
   output logic                  o_ARREADY,
   output logic [1:0]            o_ARBURST,
   input  logic                  i_AWREADY,
   output logic                  o_AWVALID,
   output logic [DATA_WIDTH-1:0] o_AWDATA,
   output logic [1:0]            o_AWBURST,
   input  logic [IDX_W-1:0]      i_SAMPLES_NUMBER,
   input  logic                  i_CALC_END,
   output logic                  o_DATA_LOADED,
   output logic [DATA_WIDTH-1:0] o_SAMPLE_ram,
   output logic [IDX_W-1:0]      o_SAMPLE_INDEX_ram,
   output logic                  o_WRITE_ram,
   output logic                  o_READ_ram,
   input  logic [DATA_WIDTH-1:0] i_DATA_FROM_RAM,
   output bridge_fsm             current_state
);

   logic [IDX_W-1:0] index;
   logic [IDX_W-1:0] n_reg;
   logic             last;

   assign last = (index == n_reg - IDX_ONE);

   assign o_ARBURST          = BURST_INCR;
   assign o_AWBURST          = BURST_INCR;
   assign o_SAMPLE_ram       = i_ARDATA;
   assign o_AWDATA           = i_DATA_FROM_RAM;
   assign o_SAMPLE_INDEX_ram = index;

   // State, sample index and latched transfer length
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         current_state <= IDLE;
         index         <= '0;
         n_reg         <= '0;
      end else begin
         unique case (current_state)
            IDLE: begin
               if (i_ARVALID && (i_SAMPLES_NUMBER != '0)) begin
                  n_reg         <= i_SAMPLES_NUMBER;
                  index         <= '0;
                  current_state <= READ;
               end
            end
            READ: begin
               if (i_ARVALID) begin
                  if (last) begin
                     index         <= '0;
                     current_state <= WAIT;
                  end else begin
                     index <= index + IDX_ONE;
                  end
               end
            end
            WAIT: begin
               if (i_CALC_END) begin
                  current_state <= WRITE;
               end
            end
            WRITE: begin
               if (i_AWREADY) begin
                  if (last) begin
                     index         <= '0;
                     current_state <= IDLE;
                  end else begin
                     index <= index + IDX_ONE;
                  end
               end
            end
            default: current_state <= IDLE;
         endcase
      end
   end

   // Handshake and RAM strobes decoded from the current state
   always_comb begin
      o_ARREADY     = 1'b0;
      o_WRITE_ram   = 1'b0;
      o_READ_ram    = 1'b0;
      o_AWVALID     = 1'b0;
      o_DATA_LOADED = 1'b0;
      unique case (1'b1)
         (current_state == IDLE): begin
         end
         (current_state == READ): begin
            o_ARREADY   = 1'b1;
            o_WRITE_ram = i_ARVALID;
         end
         (current_state == WAIT): begin
            o_DATA_LOADED = 1'b1;
         end
         (current_state == WRITE): begin
            o_READ_ram = 1'b1;
            o_AWVALID  = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_axi_bridge.sv
// tb_axi_bridge: directed + randomized load/unload sequences
// checked against a transaction-level model of the bridge.
module tb_axi_bridge;
   import axi_bridge_pkg::*;

   localparam int DW = 32;

   logic            i_clk;
   logic            i_rst;
   logic [DW-1:0]   i_ARDATA;
   logic            i_ARVALID;
   logic            o_ARREADY;
   logic [1:0]      o_ARBURST;
   logic            i_AWREADY;
   logic            o_AWVALID;
   logic [DW-1:0]   o_AWDATA;
   logic [1:0]      o_AWBURST;
   logic [11:0]     i_SAMPLES_NUMBER;
   logic            i_CALC_END;
   logic            o_DATA_LOADED;
   logic [DW-1:0]   o_SAMPLE_ram;
   logic [11:0]     o_SAMPLE_INDEX_ram;
   logic            o_WRITE_ram;
   logic            o_READ_ram;
   logic [DW-1:0]   i_DATA_FROM_RAM;
   bridge_fsm       current_state;

   int checks = 0;
   int errors = 0;

   // sample RAM filled by the bridge, and the FFT result RAM
   logic [DW-1:0] ram [0:4095];
   logic [DW-1:0] res [0:4095];
   logic [DW-1:0] exp_q [$];

   axi_bridge #(.DATA_WIDTH(DW)) dut (
      .i_clk              (i_clk),
      .i_rst              (i_rst),
      .i_ARDATA           (i_ARDATA),
      .i_ARVALID          (i_ARVALID),
      .o_ARREADY          (o_ARREADY),
      .o_ARBURST          (o_ARBURST),
      .i_AWREADY          (i_AWREADY),
      .o_AWVALID          (o_AWVALID),
      .o_AWDATA           (o_AWDATA),
      .o_AWBURST          (o_AWBURST),
      .i_SAMPLES_NUMBER   (i_SAMPLES_NUMBER),
      .i_CALC_END         (i_CALC_END),
      .o_DATA_LOADED      (o_DATA_LOADED),
      .o_SAMPLE_ram       (o_SAMPLE_ram),
      .o_SAMPLE_INDEX_ram (o_SAMPLE_INDEX_ram),
      .o_WRITE_ram        (o_WRITE_ram),
      .o_READ_ram         (o_READ_ram),
      .i_DATA_FROM_RAM    (i_DATA_FROM_RAM),
      .current_state      (current_state)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // RAM read path is combinational on the address
   assign i_DATA_FROM_RAM = res[o_SAMPLE_INDEX_ram];

   // emulated sample RAM write port
   always @(posedge i_clk) begin
      if (o_WRITE_ram === 1'b1)
         ram[o_SAMPLE_INDEX_ram] <= o_SAMPLE_ram;
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic do_load(input int n, input bit stall,
                          input bit rnd);
      int k;
      int cyc;
      bit v;
      logic [DW-1:0] d;
      k = 0;
      cyc = 0;
      exp_q.delete();
      d = $urandom;
      i_SAMPLES_NUMBER = 12'(n);
      i_ARVALID = 1'b1;
      i_ARDATA = d;
      settle();
      chk("start_state", 64'(current_state), 64'(IDLE));
      chk("start_arready", 64'(o_ARREADY), 64'd0);
      chk("start_write", 64'(o_WRITE_ram), 64'd0);
      tick();
      while (k < n && cyc < 10 * n + 50) begin
         v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (stall && cyc >= 4 && cyc < 7)
            v = 1'b0;
         d = d + 1;
         i_ARDATA = d;
         i_ARVALID = v;
         i_SAMPLES_NUMBER = 12'($urandom);
         i_CALC_END = 1'($urandom);
         settle();
         chk("ld_state", 64'(current_state), 64'(READ));
         chk("ld_arready", 64'(o_ARREADY), 64'd1);
         chk("ld_write", 64'(o_WRITE_ram), 64'(v));
         chk("ld_index", 64'(o_SAMPLE_INDEX_ram), 64'(k));
         chk("ld_loaded", 64'(o_DATA_LOADED), 64'd0);
         if (v) begin
            chk("ld_sample", 64'(o_SAMPLE_ram), 64'(d));
            exp_q.push_back(d);
            k++;
         end
         tick();
         cyc++;
      end
      chk("ld_count", 64'(k), 64'(n));
      i_ARVALID = 1'b0;
      i_CALC_END = 1'b0;
      settle();
      chk("wait_state", 64'(current_state), 64'(WAIT));
      chk("wait_loaded", 64'(o_DATA_LOADED), 64'd1);
      chk("wait_arready", 64'(o_ARREADY), 64'd0);
      chk("wait_index", 64'(o_SAMPLE_INDEX_ram), 64'd0);
      for (int i = 0; i < k; i++)
         chk("ram_content", 64'(ram[i]), 64'(exp_q[i]));
   endtask

   task automatic do_unload(input int n, input bit bp,
                            input bit rnd);
      int k;
      int cyc;
      bit r;
      logic [DW-1:0] base;
      k = 0;
      cyc = 0;
      base = $urandom;
      for (int i = 0; i < n; i++)
         res[i] = base + DW'(2 * i);
      // core still busy; stray source traffic is ignored
      for (int i = 0; i < 2; i++) begin
         i_ARVALID = 1'b1;
         i_ARDATA = $urandom;
         i_AWREADY = 1'b1;
         settle();
         chk("hold_state", 64'(current_state), 64'(WAIT));
         chk("hold_loaded", 64'(o_DATA_LOADED), 64'd1);
         chk("hold_write", 64'(o_WRITE_ram), 64'd0);
         chk("hold_awvalid", 64'(o_AWVALID), 64'd0);
         tick();
      end
      i_ARVALID = 1'b0;
      i_CALC_END = 1'b1;
      tick();
      i_CALC_END = 1'b0;
      while (k < n && cyc < 10 * n + 50) begin
         r = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (bp && cyc >= 3 && cyc < 5)
            r = 1'b0;
         i_AWREADY = r;
         i_ARVALID = 1'($urandom);
         settle();
         chk("ul_state", 64'(current_state), 64'(WRITE));
         chk("ul_awvalid", 64'(o_AWVALID), 64'd1);
         chk("ul_read", 64'(o_READ_ram), 64'd1);
         chk("ul_write", 64'(o_WRITE_ram), 64'd0);
         chk("ul_loaded", 64'(o_DATA_LOADED), 64'd0);
         chk("ul_index", 64'(o_SAMPLE_INDEX_ram), 64'(k));
         chk("ul_awdata", 64'(o_AWDATA),
             64'(base + DW'(2 * k)));
         if (r)
            k++;
         tick();
         cyc++;
      end
      chk("ul_count", 64'(k), 64'(n));
      i_AWREADY = 1'b0;
      i_ARVALID = 1'b0;
      settle();
      chk("end_state", 64'(current_state), 64'(IDLE));
      chk("end_awvalid", 64'(o_AWVALID), 64'd0);
      chk("end_read", 64'(o_READ_ram), 64'd0);
      chk("end_index", 64'(o_SAMPLE_INDEX_ram), 64'd0);
   endtask

   initial begin
      int n;
      i_rst = 1'b1;
      i_ARDATA = '0;
      i_ARVALID = 1'b0;
      i_AWREADY = 1'b0;
      i_SAMPLES_NUMBER = '0;
      i_CALC_END = 1'b0;
      for (int i = 0; i < 4096; i++)
         res[i] = '0;

      tick();
      tick();
      chk("rst_state", 64'(current_state), 64'(IDLE));
      chk("rst_arready", 64'(o_ARREADY), 64'd0);
      chk("rst_awvalid", 64'(o_AWVALID), 64'd0);
      chk("rst_write", 64'(o_WRITE_ram), 64'd0);
      chk("rst_read", 64'(o_READ_ram), 64'd0);
      chk("rst_loaded", 64'(o_DATA_LOADED), 64'd0);
      chk("rst_index", 64'(o_SAMPLE_INDEX_ram), 64'd0);
      chk("arburst", 64'(o_ARBURST), 64'd1);
      chk("awburst", 64'(o_AWBURST), 64'd1);
      i_rst = 1'b0;
      tick();

      do_load(10, 1'b1, 1'b0);
      do_unload(10, 1'b1, 1'b0);

      // zero-length request never leaves IDLE
      i_SAMPLES_NUMBER = '0;
      i_ARVALID = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("n0_state", 64'(current_state), 64'(IDLE));
         chk("n0_arready", 64'(o_ARREADY), 64'd0);
         chk("n0_write", 64'(o_WRITE_ram), 64'd0);
      end
      i_ARVALID = 1'b0;

      do_load(1, 1'b0, 1'b0);
      do_unload(1, 1'b0, 1'b0);

      for (int t = 0; t < 3; t++) begin
         n = $urandom_range(2, 40);
         do_load(n, 1'b0, 1'b1);
         do_unload(n, 1'b0, 1'b1);
      end

      // reset in the middle of a load
      i_SAMPLES_NUMBER = 12'd20;
      i_ARVALID = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         i_ARDATA = $urandom;
         tick();
      end
      settle();
      chk("mid_index", 64'(o_SAMPLE_INDEX_ram), 64'd5);
      i_rst = 1'b1;
      i_ARVALID = 1'b0;
      tick();
      i_rst = 1'b0;
      settle();
      chk("mid_rst_state", 64'(current_state), 64'(IDLE));
      chk("mid_rst_index", 64'(o_SAMPLE_INDEX_ram), 64'd0);
      chk("mid_rst_loaded", 64'(o_DATA_LOADED), 64'd0);
      chk("mid_rst_arready", 64'(o_ARREADY), 64'd0);
      chk("mid_rst_write", 64'(o_WRITE_ram), 64'd0);
      tick();

      do_load(5, 1'b0, 1'b1);
      do_unload(5, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
